lane_demux4: RTL and testbench
==============================

# lane_demux4

Registered 1-to-4 byte demultiplexer with valid/ready handshaking. It is the distributing counterpart of the 4:1 select muxes in the shifter datapath. It takes one 8-bit input stream and steers each accepted byte into one of four output lanes. Each lane has a one-entry holding register, so producers and consumers are decoupled. Lane choice is either an explicit 2-bit select or an internal round-robin pointer. The block also maintains a running count of accepted bytes.

## Interface
- `WIDTH`, default 8: data width of the input and of each lane.
- `CNT_W`, default 16: width of the accepted-byte counter.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `mode`  input  1  0 = explicit select via `in_sel`; 1 = round-robin.
- `in_valid`  input  1  `in_data` is offered.
- `in_ready`  output  1  block can accept `in_data` this cycle.
- `in_data`  input  WIDTH  byte to distribute.
- `in_sel`  input  2  target lane when `mode`=0; ignored when `mode`=1.
- `out_valid`  output  4  bit i set = lane i holds a byte.
- `out_ready`  input  4  bit i set = consumer i takes lane i this cycle.
- `out_data0`..`out_data3`  output  WIDTH each  lane holding registers.
- `rr_ptr`  output  2  current round-robin pointer.
- `acc_cnt`  output  CNT_W  count of accepted bytes.

## Operation
Definitions:
- Target lane: `tgt = mode ? rr_ptr : in_sel`.
- Accept: `acc = in_valid & in_ready`.
- Drain of lane i: `drn[i] = out_valid[i] & out_ready[i]`.
- Ready: `in_ready = rst_n & (~out_valid[tgt] | out_ready[tgt])`. This is combinational; the full-lane pass-through case is allowed. `in_ready` does not depend on `in_valid`.

Lane i update each cycle, in priority order:
1. `acc & tgt==i`: `out_data_i <= in_data`; `out_valid[i] <= 1`. Applies even when `drn[i]` is also true (simultaneous drain and refill).
2. Else if `drn[i]`: `out_valid[i] <= 0`; `out_data_i` holds its value.
3. Else: hold.

Non-target lanes drain independently in the same cycle; all four lanes may drain at once.

Round-robin pointer:
- Advances by 1 on every accept, wrapping 3→0, in both modes.
- This means switching `mode` 0→1 resumes from wherever the pointer last stood. Changing `mode` needs no handshake.
- In `mode`=1, a full, non-draining lane at `rr_ptr` stalls input. The block never skips a lane.

Counter and errors:
- `acc_cnt` increments by 1 per accept and wraps from 2^CNT_W−1 to 0.
- There are no error outputs.
- Data offered while `in_ready`=0 is not consumed. The source must hold it stable until accepted; this rule is not checked in RTL.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `out_valid`=4'b0000, all `out_dataN`=0, `rr_ptr`=0, `acc_cnt`=0.
  - `in_ready`=0 for the whole cycle in which `rst_n` is low.
- Reset mid-transfer discards all held bytes. No drains are reported for them.
- Latency: a byte accepted at edge k appears on `out_dataN` with `out_valid[N]`=1 after edge k.
- Throughput: one byte per cycle when the target lane is empty or draining in that same cycle.
- A lane holds its byte indefinitely while `out_ready[i]`=0.
- All outputs except `in_ready` are registered.

## Test plan
- **Reset values:** hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `acc_cnt`=0, `rr_ptr`=0; after release, `in_ready`=1.
- **Explicit select, back-to-back:** `mode`=0, `out_ready`=4'hF; send 0x11/sel 2, then 0x22/sel 0 on consecutive cycles → `out_data2`=0x11 with `out_valid`=4'b0100 one cycle after the first accept; next cycle `out_data0`=0x22 with `out_valid`=4'b0001; `acc_cnt`=2.
- **Full-lane stall and pass-through:** lane 1 holds 0xA5 with `out_ready[1]`=0; offer 0x5A/sel 1 → `in_ready`=0 and the byte is held. Raise `out_ready[1]` → `in_ready`=1 the same cycle; next cycle `out_data1`=0x5A with `out_valid[1]` still 1.
- **Round-robin wrap:** `mode`=1, all `out_ready`=1; send 0x01..0x05 → bytes land in lanes 0,1,2,3,0 in order; `rr_ptr`=1 afterwards.
- **Round-robin stall:** `mode`=1, `out_ready[2]`=0 with lane 2 full, `rr_ptr`=2 → `in_ready`=0. Lanes 0, 1 and 3 still drain normally. Releasing `out_ready[2]` resumes input into lane 2.
- **Counter wrap and mid-operation reset:** preload traffic to reach `acc_cnt`=0xFFFF, accept one more byte → `acc_cnt`=0. Then assert `rst_n`=0 with two lanes full → next cycle `out_valid`=0 and all data registers are 0.

Source files
------------

// File: rtl/lane_demux4.sv
// lane_demux4: registered 1-to-4 demultiplexer with valid/ready handshaking.
// Each accepted input byte is steered into one of four one-entry lane
// registers. The lane is chosen by an explicit select or by a round-robin
// pointer. A running count of accepted bytes is kept alongside.
module lane_demux4 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [1:0]       rr_ptr,
    output logic [CNT_W-1:0] acc_cnt
);

    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [1:0]       rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] tgt;
    logic       acc;
    logic [3:0] drn;

    // Handshake decode and next-state for lanes, pointer and counter.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        data_d  = data_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;

        tgt      = mode ? rr_q : in_sel;
        // A full target lane that drains this cycle can be refilled at once.
        in_ready = rst_n & (~valid_q[tgt] | out_ready[tgt]);
        acc      = in_valid & in_ready;
        drn      = valid_q & out_ready;

        for (int i = 0; i < 4; i++) begin
            if (acc && (tgt == 2'(i))) begin
                // Refill wins over a simultaneous drain of the same lane.
                data_d[i]  = in_data;
                valid_d[i] = 1'b1;
            end else if (drn[i]) begin
                valid_d[i] = 1'b0;
            end
        end

        if (acc) begin
            rr_d  = rr_q + 2'd1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            // NOTE: the lane data registers are cleared too, because held bytes must read as zero after reset.
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign rr_ptr    = rr_q;
    assign acc_cnt   = cnt_q;

endmodule

// File: tb/tb_lane_demux4.sv
// Directed testbench for lane_demux4 with a scoreboard of expected lane writes.
module tb_lane_demux4;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    typedef struct {
        int         lane;
        logic [7:0] data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] acc_cnt;

    int         n_checks;
    int         n_errors;
    exp_t       sb_q[$];
    logic [15:0] exp_cnt;
    logic [1:0]  exp_rr;

    lane_demux4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .rr_ptr    (rr_ptr),
        .acc_cnt   (acc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lane_data(input int lane);
        case (lane)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte that the model expects to be accepted this cycle, then
    // compare the scoreboard entry against the lane it should land in.
    task automatic send_byte(input logic [7:0] d, input logic [1:0] sel);
        exp_t e;
        exp_t got;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = sel;
        #1;
        check("in_ready_send", 32'(in_ready), 32'd1);
        e.lane = mode ? int'(exp_rr) : int'(sel);
        e.data = d;
        sb_q.push_back(e);
        exp_cnt = exp_cnt + 16'd1;
        exp_rr  = exp_rr + 2'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        got = sb_q.pop_front();
        check("lane_data", 32'(lane_data(got.lane)), 32'(got.data));
        check("lane_valid", 32'(out_valid[got.lane]), 32'd1);
        check("acc_cnt", 32'(acc_cnt), 32'(exp_cnt));
        check("rr_ptr", 32'(rr_ptr), 32'(exp_rr));
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_cnt   = '0;
        exp_rr    = '0;
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        in_sel    = 2'd0;
        out_ready = 4'h0;

        // Reset held two cycles with a byte on offer.
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_acc_cnt", 32'(acc_cnt), 32'd0);
        check("rst_rr_ptr", 32'(rr_ptr), 32'd0);
        check("rst_data0", 32'(out_data0), 32'd0);
        check("rst_data3", 32'(out_data3), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Explicit select, back-to-back.
        mode      = 1'b0;
        out_ready = 4'hF;
        send_byte(8'h11, 2'd2);
        check("b2b_valid_1", 32'(out_valid), 32'b0100);
        send_byte(8'h22, 2'd0);
        check("b2b_valid_2", 32'(out_valid), 32'b0001);
        check("b2b_cnt", 32'(acc_cnt), 32'd2);
        step();
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Full-lane stall, then pass-through refill.
        out_ready = 4'b1101;
        send_byte(8'hA5, 2'd1);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_sel   = 2'd1;
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        step();
        check("stall_hold_data", 32'(out_data1), 32'hA5);
        check("stall_hold_valid", 32'(out_valid[1]), 32'd1);
        check("stall_cnt", 32'(acc_cnt), 32'(exp_cnt));
        out_ready = 4'hF;
        send_byte(8'h5A, 2'd1);
        step();
        check("pass_drained", 32'(out_valid), 32'd0);

        // Round-robin wrap from pointer 0.
        mode = 1'b1;
        check("rr_start", 32'(rr_ptr), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 2'd3);
        end
        check("rr_wrap_ptr", 32'(rr_ptr), 32'd1);
        step();

        // Round-robin stall on a full lane 2; other lanes keep draining.
        out_ready = 4'b1011;
        send_byte(8'h31, 2'd0);
        send_byte(8'h32, 2'd0);
        send_byte(8'h33, 2'd0);
        send_byte(8'h34, 2'd0);
        send_byte(8'h35, 2'd0);
        check("rrs_ptr", 32'(rr_ptr), 32'd2);
        in_valid = 1'b1;
        in_data  = 8'h36;
        #1;
        check("rrs_in_ready", 32'(in_ready), 32'd0);
        step();
        check("rrs_others_drained", 32'(out_valid), 32'b0100);
        check("rrs_lane2_held", 32'(out_data2), 32'h32);
        out_ready = 4'hF;
        send_byte(8'h36, 2'd0);
        check("rrs_resume_valid", 32'(out_valid), 32'b0100);
        step();

        // Counter preload up to 0xFFFF with continuous traffic.
        in_valid = 1'b1;
        while (exp_cnt != 16'hFFFF) begin
            in_data = exp_cnt[7:0];
            step();
            exp_cnt = exp_cnt + 16'd1;
            exp_rr  = exp_rr + 2'd1;
        end
        in_valid = 1'b0;
        check("cnt_max", 32'(acc_cnt), 32'hFFFF);
        check("cnt_max_rr", 32'(rr_ptr), 32'(exp_rr));
        send_byte(8'hEE, 2'd0);
        check("cnt_wrap", 32'(acc_cnt), 32'd0);
        step();

        // Mid-operation reset with lanes full.
        out_ready = 4'h0;
        send_byte(8'hC1, 2'd0);
        send_byte(8'hC2, 2'd0);
        check("pre_rst_valid", 32'(out_valid), 32'b0011);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data0", 32'(out_data0), 32'd0);
        check("mid_rst_data1", 32'(out_data1), 32'd0);
        check("mid_rst_cnt", 32'(acc_cnt), 32'd0);
        check("mid_rst_rr", 32'(rr_ptr), 32'd0);
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
